nmr_compare_voter: RTL

- Parametrised N-modular-redundancy successor to the two-core duplicate-with-compare checker.
- Collects one DATA_W word from each of N_CH MicroBlaze cores and waits for a start command.
- Then performs a word-level majority vote and reports the voted word, per-channel fault mask and status.
- Raises interrupt_prompt for the cores and holds results until every contributing core acknowledges.
- Adds an arrival timeout, so a hung core is flagged as faulty and does not deadlock the system.

---
 rtl/nmr_pkg.sv | 20 ++
 rtl/nmr_vote_core.sv | 75 +++++++
 rtl/nmr_compare_voter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/nmr_pkg.sv
// Shared types and sizing helpers for the N-modular-redundancy compare/voter.
package nmr_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    READY   = 3'd2,
    COMPARE = 3'd3,
    REPORT  = 3'd4
  } nmr_state_t;

  localparam int N_CH_MAX = 8;
  // Wide enough to count agreement among any legal channel count
  localparam int CNT_W = $clog2(N_CH_MAX + 1);

  function automatic int timer_width(input int timeout_cyc);
    return (timeout_cyc <= 2) ? 1 : $clog2(timeout_cyc);
  endfunction

endpackage

// File: rtl/nmr_vote_core.sv
// Combinational word-level majority vote over the captured channel words.
module nmr_vote_core
  import nmr_pkg::*;
#(
  parameter int N_CH   = 3,
  parameter int DATA_W = 32
) (
  input  logic [N_CH*DATA_W-1:0] words,
  input  logic [N_CH-1:0]        captured,
  input  logic [N_CH-1:0]        missing,
  output logic [DATA_W-1:0]      voted_data,
  output logic [N_CH-1:0]        fault_mask,
  output logic                   is_match,
  output logic                   no_majority
);

  logic [CNT_W-1:0]  agree_s [N_CH];
  logic              win_found_s;
  logic [DATA_W-1:0] win_word_s;
  logic              all_eq_s;

  // Count, for every channel, how many captured channels hold the same word
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      agree_s[i] = '0;
      for (int j = 0; j < N_CH; j++) begin
        if (captured[j] && (words[j*DATA_W +: DATA_W] == words[i*DATA_W +: DATA_W])) begin
          agree_s[i] = agree_s[i] + CNT_W'(1);
        end else begin
          agree_s[i] = agree_s[i];
        end
      end
    end
  end

  // Pick the lowest-index captured channel whose word has a strict majority
  always_comb begin
    win_found_s = 1'b0;
    win_word_s  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!win_found_s && captured[i] && ((2 * int'(agree_s[i])) > N_CH)) begin
        win_found_s = 1'b1;
        win_word_s  = words[i*DATA_W +: DATA_W];
      end else begin
        win_found_s = win_found_s;
        win_word_s  = win_word_s;
      end
    end
  end

  // Derive vote result, per-channel faults and the full-match flag
  always_comb begin
    all_eq_s = (missing == '0);
    for (int i = 1; i < N_CH; i++) begin
      if (words[i*DATA_W +: DATA_W] != words[DATA_W-1:0]) begin
        all_eq_s = 1'b0;
      end else begin
        all_eq_s = all_eq_s;
      end
    end
    fault_mask = '1;
    if (win_found_s) begin
      voted_data  = win_word_s;
      no_majority = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        fault_mask[i] = missing[i] | (words[i*DATA_W +: DATA_W] != win_word_s);
      end
    end else begin
      voted_data  = '0;
      no_majority = 1'b1;
    end
    is_match = all_eq_s;
  end

endmodule

// File: rtl/nmr_compare_voter.sv
// N-channel compare/voter: captures one word per core, votes on start, and
// holds registered results until every contributing core acknowledges.
module nmr_compare_voter
  import nmr_pkg::*;
#(
  parameter int N_CH        = 3,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CH*DATA_W-1:0] data_in,
  input  logic [N_CH-1:0]        data_set,
  input  logic                   start,
  input  logic [N_CH-1:0]        ack,
  output logic [DATA_W-1:0]      voted_data,
  output logic [N_CH-1:0]        fault_mask,
  output logic [N_CH-1:0]        missing_mask,
  output logic                   is_match,
  output logic                   no_majority,
  output logic                   done,
  output logic                   data_read,
  output logic                   interrupt_prompt
);

  localparam int TMR_W = timer_width(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  nmr_state_t             state_r;
  logic [N_CH*DATA_W-1:0] cap_data_r;
  logic [N_CH*DATA_W-1:0] cap_data_s;
  logic [N_CH-1:0]        captured_r;
  logic [N_CH-1:0]        captured_s;
  logic [N_CH-1:0]        acked_r;
  logic [N_CH-1:0]        acked_s;
  logic [TMR_W-1:0]       timer_r;

  logic [DATA_W-1:0]      vote_data_s;
  logic [N_CH-1:0]        vote_fault_s;
  logic                   vote_match_s;
  logic                   vote_nomaj_s;

  nmr_vote_core #(
    .N_CH   (N_CH),
    .DATA_W (DATA_W)
  ) u_vote (
    .words       (cap_data_r),
    .captured    (captured_r),
    .missing     (missing_mask),
    .voted_data  (vote_data_s),
    .fault_mask  (vote_fault_s),
    .is_match    (vote_match_s),
    .no_majority (vote_nomaj_s)
  );

  // Latch each channel's word the first time its data_set is seen
  always_comb begin
    cap_data_s = cap_data_r;
    for (int i = 0; i < N_CH; i++) begin
      if (data_set[i] && !captured_r[i]) begin
        cap_data_s[i*DATA_W +: DATA_W] = data_in[i*DATA_W +: DATA_W];
      end else begin
        cap_data_s[i*DATA_W +: DATA_W] = cap_data_r[i*DATA_W +: DATA_W];
      end
    end
    captured_s = captured_r | data_set;
    acked_s    = acked_r | ack;
  end

  // Control FSM with capture, timer, ack tracking and registered results
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r          <= IDLE;
      cap_data_r       <= '0;
      captured_r       <= '0;
      acked_r          <= '0;
      timer_r          <= '0;
      voted_data       <= '0;
      fault_mask       <= '0;
      missing_mask     <= '0;
      is_match         <= 1'b0;
      no_majority      <= 1'b0;
      done             <= 1'b0;
      data_read        <= 1'b0;
      interrupt_prompt <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|data_set) begin
            state_r    <= COLLECT;
            cap_data_r <= cap_data_s;
            captured_r <= captured_s;
            timer_r    <= '0;
          end
        end
        COLLECT: begin
          cap_data_r <= cap_data_s;
          captured_r <= captured_s;
          timer_r    <= timer_r + TMR_W'(1);
          // A capture landing on the deadline cycle still counts as on time
          if (&captured_s) begin
            state_r          <= READY;
            missing_mask     <= '0;
            data_read        <= 1'b1;
            interrupt_prompt <= 1'b1;
          end else if (timer_r == TMR_LAST) begin
            state_r          <= READY;
            missing_mask     <= ~captured_s;
            data_read        <= 1'b1;
            interrupt_prompt <= 1'b1;
          end
        end
        READY: begin
          if (start) begin
            state_r          <= COMPARE;
            interrupt_prompt <= 1'b0;
          end
        end
        COMPARE: begin
          state_r          <= REPORT;
          voted_data       <= vote_data_s;
          fault_mask       <= vote_fault_s;
          is_match         <= vote_match_s;
          no_majority      <= vote_nomaj_s;
          done             <= 1'b1;
          interrupt_prompt <= 1'b1;
          acked_r          <= '0;
        end
        REPORT: begin
          acked_r <= acked_s;
          // Channels that never delivered are excused from acknowledging
          if (&(acked_s | missing_mask)) begin
            state_r          <= IDLE;
            cap_data_r       <= '0;
            captured_r       <= '0;
            acked_r          <= '0;
            timer_r          <= '0;
            voted_data       <= '0;
            fault_mask       <= '0;
            missing_mask     <= '0;
            is_match         <= 1'b0;
            no_majority      <= 1'b0;
            done             <= 1'b0;
            data_read        <= 1'b0;
            interrupt_prompt <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
